// File: rtl/pipe_backbus_gen_if.sv
// EX-side inputs and MEM/WB forwarding buses of the back-bus generator; no storage.
// Latency: none (wires only). Backpressure: hold freezes the producer; stall is returned upstream.
interface pipe_backbus_gen_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic              hold;
    logic              ex_valid;
    logic              ex_regWrite;
    logic              ex_isLoad;
    logic [4:0]        ex_rd;
    logic [XLEN-1:0]   ex_alu;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic              ex_useRs;
    logic              ex_useRt;
    logic [XLEN-1:0]   mem_rdata;
    logic [XLEN+5:0]   MEM_BACK;
    logic [XLEN+5:0]   WB_BACK;
    logic              USE_MEM_BACK;
    logic              USE_WB_BACK;
    logic              stall;
    logic              rf_we;
    logic [4:0]        rf_wa;
    logic [XLEN-1:0]   rf_wd;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        input  hold, ex_valid, ex_regWrite, ex_isLoad, ex_rd, ex_alu,
               ex_rs, ex_rt, ex_useRs, ex_useRt, mem_rdata,
        output MEM_BACK, WB_BACK, USE_MEM_BACK, USE_WB_BACK, stall,
               rf_we, rf_wa, rf_wd, stall_cnt
    );

    modport slave (
        output hold, ex_valid, ex_regWrite, ex_isLoad, ex_rd, ex_alu,
               ex_rs, ex_rt, ex_useRs, ex_useRt, mem_rdata,
        input  MEM_BACK, WB_BACK, USE_MEM_BACK, USE_WB_BACK, stall,
               rf_we, rf_wa, rf_wd, stall_cnt
    );
endinterface

// File: rtl/pipe_backbus_gen.sv
// MEM/WB pipeline registers driving forwarding buses and the RF write port; 1 cycle per stage.
// Backpressure: hold freezes every register; a load-use hit raises stall and injects one MEM bubble.
module pipe_backbus_gen #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    pipe_backbus_gen_if.master bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             r_mem_valid;
    logic             r_mem_regWrite;
    logic             r_mem_isLoad;
    logic [4:0]       r_mem_rd;
    logic [XLEN-1:0]  r_mem_alu;

    logic             r_wb_valid;
    logic             r_wb_regWrite;
    logic [4:0]       r_wb_rd;
    logic [XLEN-1:0]  r_wb_data;

    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_dep_rs;
    logic             w_dep_rt;
    logic             w_stall;

    assign w_dep_rs = bus.ex_useRs && (bus.ex_rs == r_mem_rd);
    assign w_dep_rt = bus.ex_useRt && (bus.ex_rt == r_mem_rd);

    // Load data only arrives at the end of MEM, so a consumer in EX must wait one cycle for WB.
    assign w_stall = r_mem_valid && r_mem_isLoad && r_mem_regWrite && (r_mem_rd != 5'd0) &&
                     (w_dep_rs || w_dep_rt) && bus.ex_valid && !bus.hold;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mem_valid    <= 1'b0;
            r_mem_regWrite <= 1'b0;
            r_mem_isLoad   <= 1'b0;
            r_mem_rd       <= 5'd0;
            r_mem_alu      <= '0;
        end else if (!bus.hold) begin
            if (w_stall) begin
                r_mem_valid    <= 1'b0;
                r_mem_regWrite <= 1'b0;
                r_mem_isLoad   <= 1'b0;
                r_mem_rd       <= 5'd0;
                r_mem_alu      <= '0;
            end else begin
                r_mem_valid    <= bus.ex_valid;
                r_mem_regWrite <= bus.ex_regWrite;
                r_mem_isLoad   <= bus.ex_isLoad;
                r_mem_rd       <= bus.ex_rd;
                r_mem_alu      <= bus.ex_alu;
            end
        end
    end

    // WB keeps advancing during a stall so the stalled load reaches the WB bus.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wb_valid    <= 1'b0;
            r_wb_regWrite <= 1'b0;
            r_wb_rd       <= 5'd0;
            r_wb_data     <= '0;
        end else if (!bus.hold) begin
            r_wb_valid    <= r_mem_valid;
            r_wb_regWrite <= r_mem_regWrite;
            r_wb_rd       <= r_mem_rd;
            r_wb_data     <= r_mem_isLoad ? bus.mem_rdata : r_mem_alu;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

    assign bus.MEM_BACK     = {r_mem_valid && r_mem_regWrite, r_mem_alu, r_mem_rd};
    assign bus.WB_BACK      = {r_wb_valid && r_wb_regWrite, r_wb_data, r_wb_rd};
    assign bus.USE_MEM_BACK = r_mem_valid && !r_mem_isLoad;
    assign bus.USE_WB_BACK  = r_wb_valid;
    assign bus.stall        = w_stall;
    assign bus.rf_we        = r_wb_valid && r_wb_regWrite && (r_wb_rd != 5'd0) && !bus.hold;
    assign bus.rf_wa        = r_wb_rd;
    assign bus.rf_wd        = r_wb_data;
    assign bus.stall_cnt    = r_stall_cnt;
endmodule

// File: tb/tb_pipe_backbus_gen.sv
// Randomised and directed bench: an instruction-level model predicts every output each cycle.
module tb_pipe_backbus_gen;
    localparam int XLEN  = 32;
    localparam int CNT_W = 2;

    logic clk;
    logic rstn;

    pipe_backbus_gen_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    pipe_backbus_gen #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One instruction occupying a pipeline stage.
    typedef struct packed {
        logic        valid;
        logic        wr;
        logic        ld;
        logic [4:0]  rd;
        logic [31:0] val;
    } instr_t;

    typedef struct {
        logic [37:0] mem_back;
        logic [37:0] wb_back;
        logic        use_mem;
        logic        use_wb;
        logic        stall;
        logic        rf_we;
        logic [4:0]  rf_wa;
        logic [31:0] rf_wd;
        logic [1:0]  cnt;
        string       tag;
    } exp_t;

    exp_t   sb[$];
    instr_t m_mem, m_wb;
    int     m_stalls;
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string tag, input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s/%s: got %h expected %h", tag, name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, "MEM_BACK",     {26'd0, bus.MEM_BACK}, {26'd0, e.mem_back});
            chk(e.tag, "WB_BACK",      {26'd0, bus.WB_BACK},  {26'd0, e.wb_back});
            chk(e.tag, "USE_MEM_BACK", {63'd0, bus.USE_MEM_BACK}, {63'd0, e.use_mem});
            chk(e.tag, "USE_WB_BACK",  {63'd0, bus.USE_WB_BACK},  {63'd0, e.use_wb});
            chk(e.tag, "stall",        {63'd0, bus.stall}, {63'd0, e.stall});
            chk(e.tag, "rf_we",        {63'd0, bus.rf_we}, {63'd0, e.rf_we});
            chk(e.tag, "rf_wa",        {59'd0, bus.rf_wa}, {59'd0, e.rf_wa});
            chk(e.tag, "rf_wd",        {32'd0, bus.rf_wd}, {32'd0, e.rf_wd});
            chk(e.tag, "stall_cnt",    {62'd0, bus.stall_cnt}, {62'd0, e.cnt});
        end
    end

    // Drive one cycle of inputs, predict this cycle's outputs, then advance the model past the edge.
    task automatic step(input bit rst, input bit hold, input bit v, input bit wr, input bit ld,
                        input logic [4:0] rd, input logic [31:0] alu, input logic [4:0] rs,
                        input logic [4:0] rt, input bit urs, input bit urt,
                        input logic [31:0] rdata, input string tag);
        exp_t   e;
        instr_t ex_i, nmem, nwb;
        bit     hazard;
        int     max_cnt;
        max_cnt = (1 << CNT_W) - 1;
        rstn = !rst;
        bus.hold = hold; bus.ex_valid = v; bus.ex_regWrite = wr; bus.ex_isLoad = ld;
        bus.ex_rd = rd; bus.ex_alu = alu; bus.ex_rs = rs; bus.ex_rt = rt;
        bus.ex_useRs = urs; bus.ex_useRt = urt; bus.mem_rdata = rdata;
        if (rst) begin
            m_mem = '0; m_wb = '0; m_stalls = 0;
        end
        hazard = m_mem.valid && m_mem.ld && m_mem.wr && (m_mem.rd != 0) && v && !hold &&
                 ((urs && rs == m_mem.rd) || (urt && rt == m_mem.rd));
        e.mem_back = {m_mem.valid & m_mem.wr, m_mem.val, m_mem.rd};
        e.wb_back  = {m_wb.valid & m_wb.wr, m_wb.val, m_wb.rd};
        e.use_mem  = m_mem.valid & ~m_mem.ld;
        e.use_wb   = m_wb.valid;
        e.stall    = hazard;
        e.rf_we    = m_wb.valid && m_wb.wr && (m_wb.rd != 0) && !hold;
        e.rf_wa    = m_wb.rd;
        e.rf_wd    = m_wb.val;
        e.cnt      = 2'(m_stalls);
        e.tag      = tag;
        sb.push_back(e);
        ex_i = '{valid: v, wr: wr, ld: ld, rd: rd, val: alu};
        nmem = hazard ? instr_t'('0) : ex_i;
        nwb  = '{valid: m_mem.valid, wr: m_mem.wr, ld: 1'b0, rd: m_mem.rd,
                 val: (m_mem.ld ? rdata : m_mem.val)};
        @(posedge clk);
        if (!rst) begin
            if (!hold) begin
                m_mem = nmem;
                m_wb  = nwb;
            end
            if (hazard && m_stalls < max_cnt) m_stalls++;
        end
        #1;
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 0, 0, 32'd0, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_mem = '0; m_wb = '0; m_stalls = 0;
        rstn = 1'b0;
        bus.hold = 0; bus.ex_valid = 0; bus.ex_regWrite = 0; bus.ex_isLoad = 0;
        bus.ex_rd = 0; bus.ex_alu = 0; bus.ex_rs = 0; bus.ex_rt = 0;
        bus.ex_useRs = 0; bus.ex_useRt = 0; bus.mem_rdata = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++)
            step(1, $urandom_range(0, 1), 1, 1, $urandom_range(0, 1), 5'($urandom), $urandom,
                 5'($urandom), 5'($urandom), 1, 1, $urandom, "reset");
        idle("post_reset0");
        idle("post_reset1");

        step(0, 0, 1, 1, 0, 5'd5, 32'h10, 5'd1, 5'd2, 1, 1, 32'h0, "alu_issue");
        idle("alu_mem");
        idle("alu_wb");

        step(0, 0, 1, 1, 1, 5'd8, 32'h100, 5'd0, 5'd0, 0, 0, 32'h0, "ld_issue");
        step(0, 0, 1, 1, 0, 5'd3, 32'h7, 5'd8, 5'd1, 1, 0, 32'hDEADBEEF, "ld_use_stall");
        step(0, 0, 1, 1, 0, 5'd3, 32'h7, 5'd8, 5'd1, 1, 0, 32'h0, "ld_use_retry");
        idle("ld_use_drain0");
        idle("ld_use_drain1");

        step(0, 0, 1, 1, 1, 5'd0, 32'h200, 5'd0, 5'd0, 0, 0, 32'h0, "ld_r0_issue");
        step(0, 0, 1, 1, 0, 5'd4, 32'h1, 5'd0, 5'd0, 1, 1, 32'h12345678, "ld_r0_nostall");
        idle("ld_r0_wb");
        idle("ld_r0_drain");

        step(0, 0, 1, 1, 1, 5'd9, 32'h300, 5'd0, 5'd0, 0, 0, 32'h0, "hold_ld");
        for (int i = 0; i < 3; i++)
            step(0, 1, 1, 1, 0, 5'd6, 32'h2, 5'd1, 5'd9, 0, 1, 32'h0, "hold_freeze");
        step(0, 0, 1, 1, 0, 5'd6, 32'h2, 5'd1, 5'd9, 0, 1, 32'hCAFEF00D, "hold_release");
        step(0, 0, 1, 1, 0, 5'd6, 32'h2, 5'd1, 5'd9, 0, 1, 32'h0, "hold_retry");
        idle("hold_drain");

        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 1, 1, 5'd2, 32'h40 + 32'(i), 5'd0, 5'd0, 0, 0, 32'h0, "sat_ld");
            step(0, 0, 1, 1, 0, 5'd7, 32'h5, 5'd2, 5'd2, 1, 1, 32'hA0 + 32'(i), "sat_stall");
        end
        idle("sat_end0");
        idle("sat_end1");

        // Reset while a load-use hit is pending: stall must drop without a clock edge.
        step(0, 0, 1, 1, 1, 5'd10, 32'h500, 5'd0, 5'd0, 0, 0, 32'h0, "mid_rst_ld");
        bus.ex_valid = 1; bus.ex_rs = 5'd10; bus.ex_useRs = 1; bus.ex_isLoad = 0;
        #1;
        chk("mid_rst", "stall_before", {63'd0, bus.stall}, 64'd1);
        rstn = 1'b0;
        #1;
        chk("mid_rst", "stall_async", {63'd0, bus.stall}, 64'd0);
        chk("mid_rst", "mem_back_async", {26'd0, bus.MEM_BACK}, 64'd0);
        @(posedge clk); #1;
        m_mem = '0; m_wb = '0; m_stalls = 0;
        step(1, 0, 1, 1, 0, 5'd3, 32'h0, 5'd10, 5'd0, 1, 0, 32'h0, "mid_rst_hold");
        idle("mid_rst_release");

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom, "random");
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
